echo_tof_meter: RTL

ECHO_TOF_METER -- requirements
Module: echo_tof_meter

---
 rtl/echo_tof_meter_if.sv | 19 +
 rtl/echo_tof_meter.sv | 106 ++++++++++
 2 files changed

// File: rtl/echo_tof_meter_if.sv
// Result stream of the echo time-of-flight meter.
// The master side drives one strobe per measurement.
interface echo_tof_meter_if;
  logic [15:0] tof_data;
  logic        tof_valid;
  logic        tof_timeout;

  modport master (
    output tof_data,
    output tof_valid,
    output tof_timeout
  );

  modport slave (
    input tof_data,
    input tof_valid,
    input tof_timeout
  );
endinterface

// File: rtl/echo_tof_meter.sv
// Ultrasonic echo time-of-flight meter: periodic burst,
// blanking, listen window and one result strobe per period.
module echo_tof_meter #(
  parameter int PULSE_CYCLES   = 500,
  parameter int BLANK_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int PERIOD_CYCLES  = 65000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        echo_in,
  output logic        pulse_out,
  output logic [15:0] tof_data,
  output logic        tof_valid,
  output logic        tof_timeout,
  output logic        busy
);

  localparam logic [15:0] P_END = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] B_END = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] T_END = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] R_END = 16'(PERIOD_CYCLES - 1);
  localparam logic [15:0] C_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    BLANK,
    LISTEN,
    HOLDOFF
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        rise;
  logic        cap_echo;
  logic        cap_to;
  logic        cnt_load;

  // s3 keeps tracking during blanking, so an echo already
  // high on entry to LISTEN never looks like a new edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= echo_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable) state_n = PULSE;
      PULSE:   if (cnt == P_END) state_n = BLANK;
      BLANK:   if (cnt == B_END) state_n = LISTEN;
      LISTEN:  if (rise || cnt == T_END) state_n = HOLDOFF;
      HOLDOFF: if (cnt == R_END)
                 state_n = enable ? PULSE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cap_echo = (state == LISTEN) && rise;
    cap_to   = (state == LISTEN) && !rise && (cnt == T_END);
    cnt_load = (state_n == PULSE) && (state != PULSE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 16'd0;
      pulse_out   <= 1'b0;
      tof_data    <= 16'd0;
      tof_valid   <= 1'b0;
      tof_timeout <= 1'b0;
    end else begin
      if (cnt_load)
        cnt <= 16'd0;
      else if (state != IDLE && cnt != C_MAX)
        cnt <= cnt + 16'd1;
      pulse_out   <= (state_n == PULSE);
      tof_valid   <= cap_echo | cap_to;
      tof_timeout <= cap_to;
      if (cap_echo)    tof_data <= cnt;
      else if (cap_to) tof_data <= C_MAX;
    end
  end

endmodule
